load_use_hazard_unit: RTL and testbench
=======================================

# load_use_hazard_unit

Stall and flush controller for the 5-stage MIPS pipeline. It sits at the ID stage and covers the hazards that the EX-stage forwarding cannot. It keeps its own shadow of the ID/EX destination, detects load-use dependencies, and freezes PC and IF/ID while inserting an ID/EX bubble. It also flushes IF/ID and ID/EX on a taken branch resolved in EX, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- BIT_WIDTH, 32, instruction word width (opcode/field positions assume 32)
- STALL_CNT_WIDTH, 16, width of the saturating stall counter

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- instr_IFID  input  BIT_WIDTH  instruction currently in IF/ID
- valid_IFID  input  1  IF/ID holds a real instruction (0 = bubble/flushed)
- branch_taken_EX  input  1  branch/jump in EX resolved taken this cycle
- PC_write  output  1  PC register load enable
- IFID_write  output  1  IF/ID register load enable
- IDEX_bubble  output  1  force ID/EX control to NOP this cycle
- IFID_flush  output  1  clear IF/ID at next edge
- IDEX_flush  output  1  clear ID/EX at next edge
- hazard_state  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH
- stall_count  output  STALL_CNT_WIDTH  number of load-use stall cycles since reset

## Operation
- Decode of instr_IFID: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
  - R-type (opcode 0): uses rs, rt; dest rd.
  - lw (100011): uses rs; dest rt; is_load=1.
  - sw (101011), beq (000100), bne (000101): use rs, rt; no dest.
  - I-type ALU (001xxx): uses rs; dest rt.
  - j (000010), jal (000011): no sources, no dest.
  - Any other opcode: no sources, no dest.
  - A dest of register 0 is treated as no dest.
- Shadow ID/EX registers: idex_valid, idex_dest[4:0], idex_is_load.
  - Load from the IF/ID decode when IFID_write=1 and no flush.
  - Cleared (idex_valid=0) when IDEX_bubble=1 or IDEX_flush=1.
- hazard = valid_IFID & idex_valid & idex_is_load & (idex_dest!=0) & ((uses_rs & rs==idex_dest) | (uses_rt & rt==idex_dest)).
- FSM:
  - RUN: branch_taken_EX → assert IFID_flush, IDEX_flush; next FLUSH. Otherwise hazard → PC_write=0, IFID_write=0, IDEX_bubble=1, stall_count+1; next STALL. Otherwise stay in RUN.
  - STALL: the load has moved to MEM and forwarding covers it. The hazard check is re-evaluated normally and will not fire again because the shadow now holds the bubble. branch_taken_EX → flush, next FLUSH. Otherwise next RUN.
  - FLUSH: the hazard check is suppressed and all enables are normal. Next RUN, unless branch_taken_EX, in which case flush again and stay in FLUSH.
- Priority: branch_taken_EX outranks hazard in every state. The stall is dropped and the counter is not incremented.
- stall_count saturates at 2^STALL_CNT_WIDTH-1.
- Outputs not listed for a state take their defaults: PC_write=1, IFID_write=1, all other outputs 0.

## Timing
- Control outputs are combinational from the current state, the shadow registers, and the inputs. They are valid in the same cycle as detection, with zero-cycle latency.
- Exactly one stall cycle per load-use pair. A dependent instruction two slots behind a load never stalls.
- State, shadow, and counter update on the rising edge of clk.
- Reset (rst=1 at an edge) sets: state RUN, idex_valid=0, idex_dest=0, idex_is_load=0, stall_count=0.
  - While in reset, outputs read: PC_write=1, IFID_write=1, IDEX_bubble=0, IFID_flush=0, IDEX_flush=0, hazard_state=00.
  - Reset mid-STALL or mid-FLUSH overrides all inputs that cycle.
- valid_IFID=0 never causes a stall.

## Test plan
- lw $8,0($9) (0x8D280000) followed by add $10,$8,$11 (0x010B5020): add cycle shows PC_write=0, IFID_write=0, IDEX_bubble=1, hazard_state 00→01→00, stall_count=1.
- lw $8,0($9) followed by sw $8,4($12) (0xAD880004): one stall via the rt match, stall_count increments by 1.
- lw $0,0($9) (0x8D200000) followed by add using $0: no stall. lw $8, then an independent instruction, then add using $8: no stall.
- lw $8 followed by add $10,$8,$11 with branch_taken_EX=1 in the same cycle: IFID_flush=IDEX_flush=1, PC_write=1, no bubble, stall_count unchanged, next state FLUSH then RUN.
- rst asserted during the STALL cycle: next cycle hazard_state=00, stall_count=0, all enables at their defaults.
- STALL_CNT_WIDTH=2, five load-use pairs: stall_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection and branch-flush control for a 5-stage MIPS
// pipeline. Sits at ID: decodes the IF/ID instruction, compares its sources
// against a private shadow of the ID/EX destination, and either freezes
// PC + IF/ID with an ID/EX bubble (load-use) or flushes both front stages
// (taken branch in EX). Control outputs are combinational (same-cycle).
module load_use_hazard_unit #(
  parameter int BIT_WIDTH       = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIT_WIDTH-1:0]       instr_IFID,
  input  logic                       valid_IFID,
  input  logic                       branch_taken_EX,
  output logic                       PC_write,
  output logic                       IFID_write,
  output logic                       IDEX_bubble,
  output logic                       IFID_flush,
  output logic                       IDEX_flush,
  output logic [1:0]                 hazard_state,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

  // Field positions assume a 32-bit word; the low bits (shamt/funct/imm) are
  // irrelevant to hazard detection.
  logic [5:0] opcode_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic       unused_bits_s;

  assign opcode_s      = instr_IFID[31:26];
  assign rs_s          = instr_IFID[25:21];
  assign rt_s          = instr_IFID[20:16];
  assign rd_s          = instr_IFID[15:11];
  assign unused_bits_s = ^instr_IFID;

  logic       uses_rs_s;
  logic       uses_rt_s;
  logic [4:0] dest_s;
  logic       is_load_s;
  logic       hazard_s;

  logic [1:0]                 state_q, state_d;
  logic                       idex_valid_q, idex_valid_d;
  logic [4:0]                 idex_dest_q, idex_dest_d;
  logic                       idex_is_load_q, idex_is_load_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Classify the IF/ID instruction: which register fields it reads and writes.
  always_comb begin
    uses_rs_s = 1'b0;
    uses_rt_s = 1'b0;
    dest_s    = 5'd0;
    is_load_s = 1'b0;
    casez (opcode_s)
      6'b000000: begin                         // R-type
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
        dest_s    = rd_s;
      end
      6'b100011: begin                         // lw
        uses_rs_s = 1'b1;
        dest_s    = rt_s;
        is_load_s = 1'b1;
      end
      6'b101011, 6'b000100, 6'b000101: begin   // sw, beq, bne
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
      end
      6'b001???: begin                         // I-type ALU
        uses_rs_s = 1'b1;
        dest_s    = rt_s;
      end
      default: begin                           // j, jal, unknown: no regs
        uses_rs_s = 1'b0;
        uses_rt_s = 1'b0;
      end
    endcase
  end

  // $0 can never carry a real dependency, so a zero shadow dest never matches.
  assign hazard_s = valid_IFID & idex_valid_q & idex_is_load_q &
                    (idex_dest_q != 5'd0) &
                    ((uses_rs_s & (rs_s == idex_dest_q)) |
                     (uses_rt_s & (rt_s == idex_dest_q)));

  // Next-state logic: a taken branch outranks a load-use stall everywhere;
  // hazards are ignored in FLUSH since the shadow was just emptied.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (branch_taken_EX) begin
            state_d = ST_FLUSH;
          end else if (hazard_s) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (branch_taken_EX) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Output decode: enables default high, all other controls low; reset forces defaults.
  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_bubble  = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    hazard_state = state_q;
    if (rst) begin
      hazard_state = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (branch_taken_EX) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (hazard_s) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
          end else begin
            PC_write = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (branch_taken_EX) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else begin
            PC_write = 1'b1;
          end
        end
        default: hazard_state = state_q;
      endcase
    end
  end

  // Shadow ID/EX tracking and saturating stall-cycle count.
  always_comb begin
    idex_valid_d   = idex_valid_q;
    idex_dest_d    = idex_dest_q;
    idex_is_load_d = idex_is_load_q;
    stall_cnt_d    = stall_cnt_q;
    if (IDEX_bubble || IDEX_flush) begin
      idex_valid_d   = 1'b0;
      idex_dest_d    = 5'd0;
      idex_is_load_d = 1'b0;
    end else if (IFID_write) begin
      idex_valid_d   = valid_IFID;
      idex_dest_d    = dest_s;
      idex_is_load_d = is_load_s;
    end else begin
      idex_valid_d   = idex_valid_q;
    end
    if (IDEX_bubble && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, shadow and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      idex_valid_q   <= 1'b0;
      idex_dest_q    <= 5'd0;
      idex_is_load_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      idex_valid_q   <= idex_valid_d;
      idex_dest_q    <= idex_dest_d;
      idex_is_load_q <= idex_is_load_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Bench for load_use_hazard_unit: a directed vector table, a saturation
// sequence on a 2-bit counter instance, and randomized traffic checked
// against a pipeline-level reference model.
module tb_load_use_hazard_unit;

  localparam logic [31:0] I_LW8  = 32'h8D28_0000; // lw  $8,0($9)
  localparam logic [31:0] I_ADD  = 32'h010B_5020; // add $10,$8,$11
  localparam logic [31:0] I_SW   = 32'hAD88_0004; // sw  $8,4($12)
  localparam logic [31:0] I_LW0  = 32'h8D20_0000; // lw  $0,0($9)
  localparam logic [31:0] I_ADD0 = 32'h000B_5020; // add $10,$0,$11
  localparam logic [31:0] I_IND  = 32'h0043_0820; // add $1,$2,$3
  localparam logic [31:0] I_Z    = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        valid;
  logic        br;

  logic        PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush;
  logic [1:0]  hazard_state;
  logic [15:0] stall_count;

  logic        PC_write_2, IFID_write_2, IDEX_bubble_2, IFID_flush_2, IDEX_flush_2;
  logic [1:0]  hazard_state_2;
  logic [1:0]  stall_count_2;

  int n_cmp = 0;
  int n_bad = 0;

  load_use_hazard_unit #(.BIT_WIDTH(32), .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .instr_IFID(instr), .valid_IFID(valid),
    .branch_taken_EX(br), .PC_write(PC_write), .IFID_write(IFID_write),
    .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .hazard_state(hazard_state), .stall_count(stall_count)
  );

  load_use_hazard_unit #(.BIT_WIDTH(32), .STALL_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .instr_IFID(instr), .valid_IFID(valid),
    .branch_taken_EX(br), .PC_write(PC_write_2), .IFID_write(IFID_write_2),
    .IDEX_bubble(IDEX_bubble_2), .IFID_flush(IFID_flush_2), .IDEX_flush(IDEX_flush_2),
    .hazard_state(hazard_state_2), .stall_count(stall_count_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        v;
    logic        br;
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic        fl;
    logic [1:0]  st;
    int          cnt;
    int          cnt2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [31:0] ins, input logic v,
                              input logic b, input logic pcw, input logic ifw,
                              input logic bub, input logic fl, input logic [1:0] st,
                              input int cnt, input int cnt2);
    vec_t t;
    t.rst = r; t.ins = ins; t.v = v; t.br = b;
    t.pcw = pcw; t.ifw = ifw; t.bub = bub; t.fl = fl; t.st = st;
    t.cnt = cnt; t.cnt2 = cnt2;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic pcw, input logic ifw,
                           input logic bub, input logic fl, input logic [1:0] st,
                           input int cnt, input int cnt2);
    chk({tag, ".PC_write"},     {31'd0, PC_write},     {31'd0, pcw});
    chk({tag, ".IFID_write"},   {31'd0, IFID_write},   {31'd0, ifw});
    chk({tag, ".IDEX_bubble"},  {31'd0, IDEX_bubble},  {31'd0, bub});
    chk({tag, ".IFID_flush"},   {31'd0, IFID_flush},   {31'd0, fl});
    chk({tag, ".IDEX_flush"},   {31'd0, IDEX_flush},   {31'd0, fl});
    chk({tag, ".hazard_state"}, {30'd0, hazard_state}, {30'd0, st});
    chk({tag, ".stall_count"},  {16'd0, stall_count},  32'(cnt));
    chk({tag, ".sat_ctrl"},
        {25'd0, PC_write_2, IFID_write_2, IDEX_bubble_2, IFID_flush_2, IDEX_flush_2, hazard_state_2},
        {25'd0, pcw, ifw, bub, fl, fl, st});
    chk({tag, ".sat_count"},    {30'd0, stall_count_2}, 32'(cnt2));
  endtask

  task automatic apply(input logic r, input logic [31:0] ins, input logic v, input logic b);
    rst = r; instr = ins; valid = v; br = b;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the pipeline looks like, not how the FSM is built.
  int m_ld;          // dest of a load now in EX (-1: none)
  bit m_after_br;    // previous cycle flushed for a branch
  bit m_after_stall; // previous cycle inserted a bubble
  int m_cnt;
  int m_cnt2;

  function automatic void mdecode(input logic [31:0] w, output bit urs, output bit urt,
                                  output int dst, output bit ld);
    int op;
    op = int'(w[31:26]);
    urs = 1'b0; urt = 1'b0; dst = 0; ld = 1'b0;
    if (op == 0) begin
      urs = 1'b1; urt = 1'b1; dst = int'(w[15:11]);
    end else if (op == 35) begin
      urs = 1'b1; dst = int'(w[20:16]); ld = 1'b1;
    end else if (op == 43 || op == 4 || op == 5) begin
      urs = 1'b1; urt = 1'b1;
    end else if (op >= 8 && op <= 15) begin
      urs = 1'b1; dst = int'(w[20:16]);
    end
  endfunction

  task automatic model_reset;
    m_ld = -1; m_after_br = 1'b0; m_after_stall = 1'b0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic rand_cycle(input int idx);
    bit urs, urt, ld, stall;
    int dst, rs, rt, mode;
    logic [31:0] w;
    logic r, v, b;
    int pick;
    int ops[11];
    ops = '{0, 35, 43, 4, 5, 8, 13, 15, 2, 3, 0};
    ops[10] = int'($urandom_range(0, 63));
    pick = int'($urandom_range(0, 10));
    w = $urandom;
    w[31:26] = 6'(ops[pick]);
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    r = ($urandom_range(0, 49) == 0);
    v = ($urandom_range(0, 9) != 0);
    b = ($urandom_range(0, 9) == 0);
    apply(r, w, v, b);

    mdecode(w, urs, urt, dst, ld);
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    mode = m_after_br ? 2 : (m_after_stall ? 1 : 0);
    stall = !r && !b && !m_after_br && v && (m_ld > 0) &&
            ((urs && rs == m_ld) || (urt && rt == m_ld));
    if (r)
      check_all($sformatf("rand%0d", idx), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, m_cnt, m_cnt2);
    else
      check_all($sformatf("rand%0d", idx), !stall, !stall, stall, b, 2'(mode), m_cnt, m_cnt2);

    if (r) begin
      model_reset();
    end else if (b) begin
      m_ld = -1; m_after_br = 1'b1; m_after_stall = 1'b0;
    end else if (stall) begin
      m_ld = -1; m_after_br = 1'b0; m_after_stall = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_ld = (v && ld && dst > 0) ? dst : -1;
      m_after_br = 1'b0; m_after_stall = 1'b0;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; instr = I_Z; valid = 1'b0; br = 1'b0;
    tick();

    // Directed table: rst, instr, valid, br | PC_write, IFID_write, bubble, flush, state, count, count2
    tbl.push_back(mk(1'b1, I_Z,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0)); // reset
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0));
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 0)); // rs stall
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1, 1));
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1, 1));
    tbl.push_back(mk(1'b0, I_SW,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1, 1)); // rt stall
    tbl.push_back(mk(1'b0, I_SW,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2, 2));
    tbl.push_back(mk(1'b0, I_LW0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_ADD0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2)); // $0: none
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_IND,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2)); // 2 behind
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2, 2)); // branch wins
    tbl.push_back(mk(1'b0, I_Z,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2, 2));
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_ADD,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2)); // invalid
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2, 2));
    tbl.push_back(mk(1'b1, I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 3)); // rst in STALL
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0));
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0));
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0));
    tbl.push_back(mk(1'b0, I_Z,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 0, 0)); // FLUSH again
    tbl.push_back(mk(1'b0, I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 0, 0));
    tbl.push_back(mk(1'b0, I_LW8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].ins, tbl[i].v, tbl[i].br);
      check_all($sformatf("vec%0d", i), tbl[i].pcw, tbl[i].ifw, tbl[i].bub, tbl[i].fl,
                tbl[i].st, tbl[i].cnt, tbl[i].cnt2);
      tick();
    end

    // Five load-use pairs: 16-bit counter climbs, 2-bit counter sticks at 3.
    for (int p = 1; p <= 5; p++) begin
      apply(1'b0, I_LW8, 1'b1, 1'b0);
      check_all($sformatf("sat%0d_lw", p), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0,
                p - 1, (p - 1 > 3) ? 3 : p - 1);
      tick();
      apply(1'b0, I_ADD, 1'b1, 1'b0);
      check_all($sformatf("sat%0d_stall", p), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0,
                p - 1, (p - 1 > 3) ? 3 : p - 1);
      tick();
      apply(1'b0, I_ADD, 1'b1, 1'b0);
      check_all($sformatf("sat%0d_after", p), 1'b1, 1'b1, 1'b0, 1'b0, 2'd1,
                p, (p > 3) ? 3 : p);
      tick();
    end

    // Randomized traffic against the reference model.
    apply(1'b1, I_Z, 1'b0, 1'b0);
    tick();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      rand_cycle(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
